// File: rtl/lagarto0_pkg.sv
// Shared core constants and types used by the fetch sequencer.
package lagarto0_pkg;

  localparam int ADDR_SIZE        = 32;
  localparam int ICACHE_LINE_SIZE = 128;
  localparam logic [ADDR_SIZE-1:0] RESET_ADDRESS = 32'h0000_0000;
  localparam int LINE_BYTES       = ICACHE_LINE_SIZE / 8;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    REFILL    = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits so the address points at the start of its icache line.
  function automatic logic [ADDR_SIZE-1:0] line_align(input logic [ADDR_SIZE-1:0] addr);
    return addr & ~ADDR_SIZE'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Three saturating 32-bit event counters for the fetch sequencer.
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hit_i,
  input  logic        miss_i,
  input  logic        stall_i,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o,
  output logic [31:0] perf_stall_o
);

  logic [31:0] hit_q, miss_q, stall_q;

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q   <= '0;
      miss_q  <= '0;
      stall_q <= '0;
    end else begin
      if (hit_i && (hit_q != '1))     hit_q   <= hit_q + 32'd1;
      if (miss_i && (miss_q != '1))   miss_q  <= miss_q + 32'd1;
      if (stall_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_hit_o   = hit_q;
  assign perf_miss_o  = miss_q;
  assign perf_stall_o = stall_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, pushes icache hit lines into the iqueue
// and runs a single-line refill from memory on a miss, then replays the lookup.
// Optional performance counters are built when LAGARTO_FETCH_PERF_EN is defined.
//
// Handshakes: mem_req_o is a level held every MISS_REQ cycle; the request counts as taken
// on any cycle where mem_req_o and mem_gnt_i are both 1. Exactly one mem_rvalid_i pulse
// follows each taken request. iq_wr_o is a push, only ever raised while iq_full_i is 0.
module fetch_ctrl
  import lagarto0_pkg::*;
#(
  parameter int                ADDR_W = ADDR_SIZE,
  parameter int                LINE_W = ICACHE_LINE_SIZE,
  parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDRESS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              iq_full_i,
  output logic              iq_wr_o,
  output logic [ADDR_W-1:0] ic_pc_o,
  input  logic              ic_hit_i,
  output logic              ic_we_o,
  output logic [ADDR_W-1:0] ic_waddr_o,
  output logic [LINE_W-1:0] ic_wline_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
`ifdef LAGARTO_FETCH_PERF_EN
  output logic [31:0]       perf_hit_o,
  output logic [31:0]       perf_miss_o,
  output logic [31:0]       perf_stall_o,
`endif
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(LINE_W / 8);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              quiet_q;     // first cycle after reset: no push, no miss
  logic              pend_q;      // redirect captured while a refill was outstanding
  logic [ADDR_W-1:0] pend_pc_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [LINE_W-1:0] wline_q;

  logic [ADDR_W-1:0] pc_seq;
  logic              run_go;      // RUN cycle allowed to look up (no redirect, no stall)
  logic              push;
  logic              miss;

  assign pc_seq = (pc_q & LINE_MASK) + LINE_INC;
  assign run_go = (state_q == RUN) && !quiet_q && !redirect_valid_i && !iq_full_i;
  assign push   = run_go && ic_hit_i;
  assign miss   = run_go && !ic_hit_i;

  // Fetch FSM, PC and refill latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      pc_q      <= RST_PC;
      quiet_q   <= 1'b1;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      waddr_q   <= '0;
      wline_q   <= '0;
    end else begin
      quiet_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (redirect_valid_i)  pc_q    <= redirect_pc_i;
          else if (push)         pc_q    <= pc_seq;
          else if (miss)         state_q <= MISS_REQ;
        end
        MISS_REQ: begin
          // A redirect abandons the miss even if memory grants in the same cycle.
          if (redirect_valid_i) begin
            pc_q    <= redirect_pc_i;
            state_q <= RUN;
          end else if (mem_gnt_i) begin
            state_q <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (redirect_valid_i) begin
            pend_q    <= 1'b1;
            pend_pc_q <= redirect_pc_i;
          end
          if (mem_rvalid_i) begin
            wline_q <= mem_rdata_i;
            waddr_q <= pc_q & LINE_MASK;
            state_q <= REFILL;
          end
        end
        REFILL: begin
          if (redirect_valid_i) pc_q <= redirect_pc_i;
          else if (pend_q)      pc_q <= pend_pc_q;
          pend_q  <= 1'b0;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign ic_pc_o    = pc_q;
  assign iq_wr_o    = !rst_i && push;
  assign ic_we_o    = !rst_i && (state_q == REFILL);
  assign ic_waddr_o = waddr_q;
  assign ic_wline_o = wline_q;
  assign mem_req_o  = !rst_i && (state_q == MISS_REQ);
  assign mem_addr_o = pc_q & LINE_MASK;
  assign busy_o     = !rst_i && (state_q != RUN);

`ifdef LAGARTO_FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .hit_i        (push),
    .miss_i       (miss),
    .stall_i      ((state_q != RUN) || iq_full_i),
    .perf_hit_o   (perf_hit_o),
    .perf_miss_o  (perf_miss_o),
    .perf_stall_o (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then randomized
// traffic against a reference model that tracks the fetch PC and refill queue.
module tb_fetch_ctrl;
  import lagarto0_pkg::*;

  localparam int AW = 32;
  localparam int LW = 128;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b0;
  logic          redirect_valid_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          iq_full_i = 1'b0;
  logic          ic_hit_i = 1'b0;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [LW-1:0] mem_rdata_i = '0;
  logic          iq_wr_o, ic_we_o, mem_req_o, busy_o;
  logic [AW-1:0] ic_pc_o, ic_waddr_o, mem_addr_o;
  logic [LW-1:0] ic_wline_o;
`ifdef LAGARTO_FETCH_PERF_EN
  logic [31:0]   perf_hit_o, perf_miss_o, perf_stall_o;
`endif

  fetch_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .iq_full_i        (iq_full_i),
    .iq_wr_o          (iq_wr_o),
    .ic_pc_o          (ic_pc_o),
    .ic_hit_i         (ic_hit_i),
    .ic_we_o          (ic_we_o),
    .ic_waddr_o       (ic_waddr_o),
    .ic_wline_o       (ic_wline_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
`ifdef LAGARTO_FETCH_PERF_EN
    .perf_hit_o       (perf_hit_o),
    .perf_miss_o      (perf_miss_o),
    .perf_stall_o     (perf_stall_o),
`endif
    .busy_o           (busy_o)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The fetcher is in one of four activities: fetching, asking memory
  // for a line, waiting for the line, or writing the line into the icache.
  localparam int FETCHING = 0, ASKING = 1, WAITING = 2, WRITING = 3;
  bit            m_valid = 1'b0;
  int            m_act = FETCHING;
  bit            m_quiet = 1'b0;
  logic [AW-1:0] m_pc = '0;
  bit            m_has_saved = 1'b0;
  logic [AW-1:0] m_saved = '0;
  logic [AW+LW-1:0] exp_q[$];   // {line address, line data} waiting to be written

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return (a / 16) * 16;
  endfunction

  // Compare DUT outputs against the model every cycle, then advance the model.
  always @(negedge clk) begin
    bit e_iq, e_we, e_req, e_busy;
    logic [AW+LW-1:0] head;
    e_iq = 0; e_we = 0; e_req = 0; e_busy = 0; head = '0;
    if (m_valid && !rst_i) begin
      e_iq   = (m_act == FETCHING) && !m_quiet && !redirect_valid_i && !iq_full_i && ic_hit_i;
      e_req  = (m_act == ASKING);
      e_we   = (m_act == WRITING);
      e_busy = (m_act != FETCHING);
    end
    if (m_valid) begin
      chk("m_pc", ic_pc_o, m_pc);
      chk("m_iq_wr", iq_wr_o, e_iq);
      chk("m_ic_we", ic_we_o, e_we);
      chk("m_mem_req", mem_req_o, e_req);
      chk("m_busy", busy_o, e_busy);
      if (e_req) chk("m_mem_addr", mem_addr_o, line_of(m_pc));
      if (e_we) begin
        if (exp_q.size() == 0) chk("m_refill_queued", 1'b0, 1'b1);
        else begin
          head = exp_q[0];
          chk("m_waddr", ic_waddr_o, head[AW+LW-1:LW]);
          chk("m_wline", ic_wline_o, head[LW-1:0]);
        end
      end
    end
    if (rst_i) begin
      m_valid = 1; m_act = FETCHING; m_quiet = 1; m_pc = RESET_ADDRESS;
      m_has_saved = 0; exp_q.delete();
    end else if (m_valid) begin
      case (m_act)
        FETCHING: begin
          if (redirect_valid_i) m_pc = redirect_pc_i;
          else if (m_quiet || iq_full_i) m_pc = m_pc;
          else if (ic_hit_i) m_pc = line_of(m_pc) + 32'd16;
          else m_act = ASKING;
        end
        ASKING: begin
          if (redirect_valid_i) begin m_pc = redirect_pc_i; m_act = FETCHING; end
          else if (mem_gnt_i) m_act = WAITING;
        end
        WAITING: begin
          if (redirect_valid_i) begin m_has_saved = 1; m_saved = redirect_pc_i; end
          if (mem_rvalid_i) begin
            exp_q.push_back({line_of(m_pc), mem_rdata_i});
            m_act = WRITING;
          end
        end
        default: begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (redirect_valid_i) m_pc = redirect_pc_i;
          else if (m_has_saved) m_pc = m_saved;
          m_has_saved = 0;
          m_act = FETCHING;
        end
      endcase
      m_quiet = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit rd, input logic [AW-1:0] rpc, input bit full,
                      input bit hit, input bit gnt, input bit rv, input logic [LW-1:0] d);
    @(posedge clk); #1;
    rst_i = r; redirect_valid_i = rd; redirect_pc_i = rpc; iq_full_i = full;
    ic_hit_i = hit; mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = d;
    #2;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [LW-1:0] d1, d2, d3, d4;
  int            resp_cnt;
  bit            outstanding;

  initial begin
    d1 = rnd_line(); d2 = rnd_line(); d3 = rnd_line(); d4 = rnd_line();

    // Reset with a hit presented, then a quiet cycle, then sequential hits.
    step(1, 0, 0, 0, 1, 0, 0, '0);
    chk("rst_iq_wr", iq_wr_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("post_rst_pc", ic_pc_o, 32'h0);
    chk("post_rst_iq_wr", iq_wr_o, 1'b0);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("seq_pc0", ic_pc_o, 32'h0);   chk("seq_wr0", iq_wr_o, 1'b1);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("seq_pc1", ic_pc_o, 32'h10);  chk("seq_wr1", iq_wr_o, 1'b1);
    // iqueue full holds the PC.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 0, 0, '0);
      chk("full_pc", ic_pc_o, 32'h20); chk("full_wr", iq_wr_o, 1'b0);
    end
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("resume_pc", ic_pc_o, 32'h20); chk("resume_wr", iq_wr_o, 1'b1);
    // Redirect beats a hit.
    step(0, 1, 32'h44, 0, 1, 0, 0, '0);
    chk("redir_hit_wr", iq_wr_o, 1'b0);
    // Miss at 0x44, grant at +1, response at +4.
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("miss_pc", ic_pc_o, 32'h44);
    step(0, 0, 0, 0, 0, 1, 0, '0);
    chk("req", mem_req_o, 1'b1); chk("req_addr", mem_addr_o, 32'h40);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("wait_req", mem_req_o, 1'b0); chk("wait_busy", busy_o, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 1, d1);
    chk("rv_we", ic_we_o, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("refill_we", ic_we_o, 1'b1); chk("refill_addr", ic_waddr_o, 32'h40);
    chk("refill_line", ic_wline_o, d1);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("replay_pc", ic_pc_o, 32'h44); chk("replay_wr", iq_wr_o, 1'b1);
    // Redirect together with a grant drops the miss.
    step(0, 0, 0, 0, 0, 0, 0, '0);
`ifdef LAGARTO_FETCH_PERF_EN
    chk("perf_hit", perf_hit_o, 32'd4); chk("perf_miss", perf_miss_o, 32'd1);
`endif
    step(0, 1, 32'h200, 0, 0, 1, 0, '0);
    chk("drop_req", mem_req_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, '0);
      chk("drop_pc", ic_pc_o, 32'h200); chk("drop_we", ic_we_o, 1'b0);
      chk("drop_busy", busy_o, 1'b0);
    end
    // Redirect during the wait: old line still written, then fetch at the target.
    step(0, 0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 0, '0);
    step(0, 1, 32'h1000, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 1, d2);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("r4_we", ic_we_o, 1'b1); chk("r4_addr", ic_waddr_o, 32'h200);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("r4_pc", ic_pc_o, 32'h1000); chk("r4_wr", iq_wr_o, 1'b1);
    // Two redirects while waiting: the last wins.
    step(0, 0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 0, '0);
    step(0, 1, 32'h2000, 0, 0, 0, 0, '0);
    step(0, 1, 32'h3000, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 1, d3);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("two_we", ic_we_o, 1'b1); chk("two_addr", ic_waddr_o, 32'h1010);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("two_pc", ic_pc_o, 32'h3000);
    // Redirect and response in the same waiting cycle.
    step(0, 0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 0, '0);
    step(0, 1, 32'h5000, 0, 0, 0, 1, d4);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("same_addr", ic_waddr_o, 32'h3010); chk("same_line", ic_wline_o, d4);
    step(0, 0, 0, 1, 0, 0, 0, '0);
    chk("same_pc", ic_pc_o, 32'h5000);
    // Sequential PC wraps at the top of the address space.
    step(0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, 0, 0, '0);
    chk("top_wr", iq_wr_o, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("wrap_pc", ic_pc_o, 32'h0);
    // Redirect without grant in MISS_REQ, then reset while the response arrives.
    step(0, 1, 32'h700, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("r6_pc", ic_pc_o, 32'h700);
    step(0, 0, 0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, 1, d1);
    chk("r6_rst_we", ic_we_o, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, '0);
    chk("r6_we", ic_we_o, 1'b0); chk("r6_pc_rst", ic_pc_o, 32'h0);
    chk("r6_busy", busy_o, 1'b0);

    // Randomized traffic with a one-outstanding memory responder.
    outstanding = 0; resp_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic req_now;
      @(posedge clk); #1;
      req_now = mem_req_o;
      rst_i = ($urandom_range(0, 99) == 0);
      redirect_valid_i = ($urandom_range(0, 9) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + $urandom_range(0, 31) : $urandom;
      iq_full_i = ($urandom_range(0, 4) == 0);
      ic_hit_i = ($urandom_range(0, 9) < 7);
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = rnd_line();
      if (rst_i) begin
        outstanding = 0;
      end else if (outstanding) begin
        if (resp_cnt == 0) begin mem_rvalid_i = 1; outstanding = 0; end
        else resp_cnt--;
      end else if (req_now && !redirect_valid_i) begin
        mem_gnt_i = $urandom_range(0, 1);
        if (mem_gnt_i) begin outstanding = 1; resp_cnt = $urandom_range(0, 4); end
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, '0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
